// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter: register offsets,
// CTRL field layout, MODE encodings and FSM state encodings.
package timer_counter_pkg;

  localparam logic [3:0] TC_CTRL   = 4'h0;
  localparam logic [3:0] TC_PRESET = 4'h4;
  localparam logic [3:0] TC_COUNT  = 4'h8;
  localparam logic [3:0] TC_RSVD   = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_RSVD2   = 2'b10,
    MODE_RSVD3   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_e;

  // Field order mirrors the CTRL register bit layout {IM, MODE, EN}.
  typedef struct packed {
    logic  im;
    mode_e mode;
    logic  en;
  } ctrl_t;

  function automatic logic [1:0] word_idx(input logic [3:0] offset);
    return offset[3:2];
  endfunction

  // Reserved MODE encodings fall back to one-shot behaviour.
  function automatic logic is_reload(input mode_e mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Register-window bus between the address bridge (master) and the timer (slave).
interface timer_counter_if #(
  parameter int ADDR_BITS = 4
);
  logic [ADDR_BITS-1:0] addr;
  logic                 we;
  logic [31:0]          wdata;
  logic [31:0]          rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with a 3-word register window (CTRL/PRESET/COUNT)
// and a flag-based interrupt request gated by CTRL.IM.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  timer_counter_if.slave    bus,
  output logic              irq
);

  logic [ADDR_BITS-1:0] addr_s;
  logic [1:0]           idx_s;
  logic                 unused_addr_s;
  logic                 wr_ctrl_s;
  logic                 wr_preset_s;
  logic                 irq_set_s;

  state_e      state_d, state_q;
  ctrl_t       ctrl_d, ctrl_q;
  logic [31:0] preset_d, preset_q;
  logic [31:0] count_d, count_q;
  logic        irq_flag_d, irq_flag_q;

  assign addr_s        = bus.addr;
  assign idx_s         = addr_s[3:2];
  assign unused_addr_s = ^addr_s[1:0];
  assign wr_ctrl_s     = bus.we && (idx_s == word_idx(TC_CTRL));
  assign wr_preset_s   = bus.we && (idx_s == word_idx(TC_PRESET));

  // Next-state, counter and register-window update logic.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    irq_set_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d   = ST_INT;
          irq_set_s = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        // Auto-reload skips IDLE so the whole period is PRESET+3 cycles.
        if (is_reload(ctrl_q.mode)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A CPU CTRL write overrides the FSM's own EN clear; expiry beats the flag clear.
    if (wr_ctrl_s) begin
      ctrl_d.en   = bus.wdata[CTRL_EN_BIT];
      ctrl_d.mode = mode_e'(bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      ctrl_d.im   = bus.wdata[CTRL_IM_BIT];
      if (!irq_set_s) begin
        irq_flag_d = 1'b0;
      end else begin
        irq_flag_d = 1'b1;
      end
    end else if (irq_set_s) begin
      irq_flag_d = 1'b1;
    end else begin
      irq_flag_d = irq_flag_d;
    end

    if (wr_preset_s) begin
      preset_d = bus.wdata;
    end else begin
      preset_d = preset_q;
    end
  end

  // State and register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Zero-wait-state read mux over the register window.
  always_comb begin
    case (idx_s)
      2'd0:    bus.rdata = {28'h0, ctrl_q};
      2'd1:    bus.rdata = preset_q;
      2'd2:    bus.rdata = count_q;
      default: bus.rdata = 32'h0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: register reads, one-shot,
// auto-reload, freeze-on-disable, masked interrupt, ignored writes and reset.
module tb_timer_counter;

  logic clk;
  logic reset;
  logic irq;
  int   n_cmp;
  int   n_err;

  timer_counter_if #(.ADDR_BITS(4)) bus ();

  timer_counter #(.ADDR_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.addr  = 4'h0;
    bus.we    = 1'b0;
    bus.wdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_preset", 4'h4, 32'h0);
    rd_chk("rst_count", 4'h8, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // One-shot PRESET=5: irq rises 8 cycles after the CTRL write
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("os_irq_low", {31'h0, irq}, 32'h0);
    end
    tick();
    check("os_irq_rise", {31'h0, irq}, 32'h1);
    rd_chk("os_count0", 4'h8, 32'h0);
    tick();
    rd_chk("os_en_cleared", 4'h0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("os_irq_held", {31'h0, irq}, 32'h1);
    end
    wr(4'h0, 32'h0);
    check("os_irq_cleared", {31'h0, irq}, 32'h0);

    // Auto-reload PRESET=2: one-cycle pulse every 5 cycles, COUNT 2,1,0 between
    wr(4'h4, 32'd2);
    wr(4'h0, 32'hB);
    bus.addr = 4'h8;
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        check("ar_irq_low", {31'h0, irq}, 32'h0);
        if (k >= 2) begin
          rd_chk("ar_count", 4'h8, 32'(4 - k));
        end
      end
      tick();
      check("ar_irq_pulse", {31'h0, irq}, 32'h1);
    end
    wr(4'h0, 32'h0);
    check("ar_stop_irq", {31'h0, irq}, 32'h0);

    // One-shot PRESET=10, disable at COUNT=4 -> freezes at 3, no irq
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    for (int i = 0; i < 8; i++) tick();
    rd_chk("fz_count4", 4'h8, 32'd4);
    wr(4'h0, 32'h8);
    for (int i = 0; i < 12; i++) tick();
    rd_chk("fz_frozen", 4'h8, 32'd3);
    check("fz_no_irq", {31'h0, irq}, 32'h0);
    wr(4'h0, 32'h9);
    tick();
    tick();
    rd_chk("fz_reload10", 4'h8, 32'd10);
    wr(4'h0, 32'h0);
    tick();
    rd_chk("fz_stop9", 4'h8, 32'd9);

    // Writes to COUNT and the reserved word are ignored
    wr(4'h8, 32'h1234);
    rd_chk("ign_count", 4'h8, 32'd9);
    wr(4'hC, 32'hFFFF_FFFF);
    rd_chk("ign_rsvd", 4'hC, 32'h0);
    rd_chk("ign_ctrl", 4'h0, 32'h0);
    rd_chk("ign_preset", 4'h4, 32'd10);

    // Masked interrupt: flag sets, irq stays low; CTRL=0x8 clears the flag
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("im_irq_low", {31'h0, irq}, 32'h0);
    end
    check("im_flag_set", {31'h0, dut.irq_flag_q}, 32'h1);
    tick();
    wr(4'h0, 32'h8);
    check("im_flag_clr", {31'h0, dut.irq_flag_q}, 32'h0);
    tick();
    check("im_irq_stays0", {31'h0, irq}, 32'h0);

    // PRESET=0 expires 3 cycles after enable; reset drops irq on that edge
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);
    tick();
    tick();
    check("p0_irq_low", {31'h0, irq}, 32'h0);
    tick();
    check("p0_irq_rise", {31'h0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    check("rst_irq_drop", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    // Reset mid-count zeroes all registers
    wr(4'h4, 32'd20);
    wr(4'h0, 32'h3);
    for (int i = 0; i < 6; i++) tick();
    rd_chk("mc_count16", 4'h8, 32'd16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("mc_ctrl0", 4'h0, 32'h0);
    rd_chk("mc_preset0", 4'h4, 32'h0);
    rd_chk("mc_count0", 4'h8, 32'h0);
    tick();
    tick();
    tick();
    rd_chk("mc_idle_count", 4'h8, 32'h0);
    check("mc_irq", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
